// File: rtl/climate_controller.sv
// Thermostat FSM: hysteresis, dwell, sample watchdog and setpoint fault.
// Optional fan level output enabled by `CLIMATE_FAN_EN.
module climate_controller #(
  parameter int TEMP_W      = 32,
  parameter int HYST        = 2,
  parameter int DWELL_CYC   = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] tempc,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] set_low,
  input  logic [TEMP_W-1:0] set_high,
  output logic              heater_on,
  output logic              cooler_on,
  output logic [1:0]        fan_speed,
  output logic              alarm
);

  typedef enum logic [1:0] {
    IDLE,
    HEAT,
    COOL,
    FAULT
  } state_t;

  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int XW = TEMP_W + 1;

  state_t        state;
  state_t        state_d;
  logic [DW-1:0] dwell;
  logic [WW-1:0] wd;

  logic [XW-1:0] t_x;
  logic [XW-1:0] lo_x;
  logic [XW-1:0] hi_x;
  logic [XW-1:0] lo_h;
  logic [XW-1:0] t_h;
  logic          sp_bad;
  logic          dwell_done;
  logic          wd_hit;
  logic          entering;

  // One extra bit keeps threshold+HYST from wrapping.
  assign t_x  = {1'b0, tempc};
  assign lo_x = {1'b0, set_low};
  assign hi_x = {1'b0, set_high};
  assign lo_h = lo_x + XW'(HYST);
  assign t_h  = t_x + XW'(HYST);

  assign sp_bad     = (lo_x >= hi_x);
  assign dwell_done = (dwell == DW'(DWELL_CYC));
  assign wd_hit     = (wd == WW'(TIMEOUT_CYC));
  assign entering   = (state_d != state) &&
                      (state_d == HEAT || state_d == COOL);

  always_comb begin
    state_d = state;
    if (temp_valid) begin
      if (sp_bad) begin
        state_d = FAULT;
      end else begin
        case (state)
          IDLE: begin
            if (t_x < lo_x)
              state_d = HEAT;
            else if (t_x > hi_x)
              state_d = COOL;
          end
          HEAT: begin
            if (t_x >= lo_h && dwell_done)
              state_d = IDLE;
          end
          COOL: begin
            if (t_h <= hi_x && dwell_done)
              state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (wd_hit && state != FAULT) begin
      state_d = FAULT;
    end
  end

`ifdef CLIMATE_FAN_EN
  logic [XW-1:0] dist;
  logic [1:0]    fan_d;

  always_comb begin
    dist = '0;
    if (state_d == HEAT && lo_x > t_x)
      dist = lo_x - t_x;
    else if (state_d == COOL && t_x > hi_x)
      dist = t_x - hi_x;
  end

  // Level follows the latest sample; held between samples.
  always_comb begin
    fan_d = fan_speed;
    if (state_d == IDLE || state_d == FAULT)
      fan_d = 2'd0;
    else if (temp_valid) begin
      if (dist < XW'(4))
        fan_d = 2'd1;
      else if (dist < XW'(8))
        fan_d = 2'd2;
      else
        fan_d = 2'd3;
    end
  end
`else
  assign fan_speed = 2'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      heater_on <= 1'b0;
      cooler_on <= 1'b0;
      alarm     <= 1'b0;
      dwell     <= '0;
      wd        <= '0;
`ifdef CLIMATE_FAN_EN
      fan_speed <= 2'd0;
`endif
    end else begin
      state     <= state_d;
      heater_on <= (state_d == HEAT);
      cooler_on <= (state_d == COOL);
      alarm     <= (state_d == FAULT);
`ifdef CLIMATE_FAN_EN
      fan_speed <= fan_d;
`endif
      if (entering)
        dwell <= '0;
      else if (!dwell_done)
        dwell <= dwell + DW'(1);
      if (temp_valid)
        wd <= '0;
      else if (!wd_hit)
        wd <= wd + WW'(1);
    end
  end

endmodule
